// File: rtl/uart_pkg.sv
// Shared UART constants and the tick-divisor calculation.
// RX/TX reuse these defaults for their own tick counts (e.g. mid-bit sampling).
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF   = 50_000_000;
  localparam int unsigned BAUD_RATE_DEF  = 9_600;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned MID_BIT_DEF    = OVERSAMPLE_DEF / 2;

  // Clock cycles per oversample tick, rounded to nearest integer.
  function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                               input int unsigned baud_rate,
                                               input int unsigned oversample);
    int unsigned tick_rate;
    tick_rate = baud_rate * oversample;
    if (tick_rate == 0) return 0;
    return (clk_freq + tick_rate / 2) / tick_rate;
  endfunction

endpackage

// File: rtl/baud_rate_generator_mod_n_counter.sv
// Modulo-N counter: counts 0..N-1 and flags the last value.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   wrap  combinational, high while count is at (or beyond) N-1
`timescale 1ns/1ps
module mod_n_counter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic clk,
  input  logic rst,
  output logic wrap
);

  logic [W-1:0] count;

  // Compare with >= so any out-of-range value still returns to 0.
  assign wrap = (count >= W'(N - 1));

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/baud_rate_generator.sv
// Free-running UART oversample tick generator.
// Emits a one-cycle pulse on `out` every DIVISOR clocks, DIVISOR being
// round(CLK_FREQ / (BAUD_RATE*OVERSAMPLE)).
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   out   registered tick, high for one cycle per period
`timescale 1ns/1ps
module baud_rate_generator
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE  = BAUD_RATE_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic out
);

  localparam int unsigned TICK_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int unsigned DIVISOR   = calc_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned CNT_W     = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

  // A divisor below 2 cannot produce a pulse that returns low between ticks.
  generate
    if (DIVISOR < 2 || TICK_RATE > CLK_FREQ / 2) begin : g_bad_divisor
      $error("baud_rate_generator: tick rate too high for clock (DIVISOR=%0d)", DIVISOR);
    end
  endgenerate

  logic wrap;

  mod_n_counter #(
    .N (DIVISOR),
    .W (CNT_W)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .wrap (wrap)
  );

  // Register the wrap decode so the tick comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= 1'b0;
    end else begin
      out <= wrap;
    end
  end

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed bench for baud_rate_generator (DIVISOR=10 instance plus a defaults instance).
`timescale 1ns/1ps
module tb_baud_rate_generator;

  logic clk = 1'b0;
  logic rst;
  logic out;
  logic out_def;

  int n_chk = 0;
  int n_bad = 0;

  always #1 clk = ~clk;

  baud_rate_generator #(
    .CLK_FREQ   (1_600_000),
    .BAUD_RATE  (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .out (out)
  );

  baud_rate_generator u_def (
    .clk (clk),
    .rst (rst),
    .out (out_def)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int last;
    int bad_gap;
    int bad_width;
    logic prev;
    int first;
    bit found;
    int period;
    int rate;
    int err;

    // Reset asserted from time zero: outputs clear without a clock edge.
    rst = 1'b0;
    #0.5;
    check("rst_async_init", 32'(out), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #0.5;
      check("rst_hold_out", 32'(out), 32'd0);
      check("rst_hold_cnt", 32'(dut.u_counter.count), 32'd0);
    end

    // First tick after release: high after edge 10, low after edge 11.
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #0.5;
      check($sformatf("first_tick_e%0d", k), 32'(out), 32'(k == 10));
    end

    // 1000 cycles: 100 pulses, one cycle wide, spaced 10 apart.
    pulses = 0; last = -1; bad_gap = 0; bad_width = 0; prev = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #0.5;
      if (out === 1'b1) begin
        pulses++;
        if (prev) bad_width++;
        if (last >= 0 && (c - last) != 10) bad_gap++;
        last = c;
      end
      prev = out;
    end
    check("period_pulses", 32'(pulses), 32'd100);
    check("period_gaps", 32'(bad_gap), 32'd0);
    check("period_width", 32'(bad_width), 32'd0);

    // Async reset between edges while out is high.
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #0.5;
      if (out === 1'b1) found = 1'b1;
    end
    check("wait_high_tick", 32'(found), 32'd1);
    #0.2;
    rst = 1'b0;
    #0.2;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_cnt", 32'(dut.u_counter.count), 32'd0);
    @(posedge clk);
    #0.5;
    check("async_rst_held", 32'(out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Mid-count reset after edge 5: next pulse 10 edges after release.
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #0.5;
      check($sformatf("post_rel_e%0d", k), 32'(out), 32'(k == 10));
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #0.5;
    end
    check("mid_cnt_before", 32'(dut.u_counter.count), 32'd5);
    rst = 1'b0;
    #0.2;
    check("mid_cnt_cleared", 32'(dut.u_counter.count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    first = -1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #0.5;
      if (out === 1'b1 && first < 0) first = k;
    end
    check("mid_restart_gap", 32'(first), 32'd10);

    // Defaults instance: measured period and resulting tick rate.
    found = 1'b0;
    for (int c = 0; c < 700 && !found; c++) begin
      @(posedge clk);
      #0.5;
      if (out_def === 1'b1) found = 1'b1;
    end
    check("def_first_tick", 32'(found), 32'd1);
    period = 0;
    found = 1'b0;
    for (int c = 1; c <= 700 && !found; c++) begin
      @(posedge clk);
      #0.5;
      if (out_def === 1'b1) begin
        found = 1'b1;
        period = c;
      end
    end
    check("def_period", 32'(period), 32'd326);
    rate = (period > 0) ? (50_000_000 / period) : 0;
    check("def_rate", 32'(rate), 32'd153374);
    err = (rate > 153600) ? (rate - 153600) : (153600 - rate);
    err = err * 10000 / 153600;
    check("def_err_lt_0p2pct", 32'(err < 20), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
